// File: rtl/phy_rx_4b5b_dec.sv
// USB-PD style 4b5b receive decoder: hunts for ordered sets, decodes data symbols into nibbles, closes the frame.
// Latency: sop_det and nibble strobes appear 1 clk after the qualifying rx_bit_vld; frame close follows 1-4 clk later.
// Backpressure: none; the downstream CRC stage must accept every strobe, and strobes are spaced at least 4 clk apart.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   rx_bit           - received line bit, sampled when rx_bit_vld=1 (first bit of a symbol is b0)
//   rx_bit_vld       - one-cycle bit strobe, at least 2 clk between strobes
//   rx_carrier       - carrier present; loss mid-frame aborts, loss while hunting clears the window
//   crc_data_in      - decoded nibble, held between strobes
//   crc_data_en      - nibble strobe, also the frame-end strobe together with crc_data_last
//   crc_data_last    - frame-end marker, only high with crc_data_en
//   sop_det          - one-cycle pulse when an ordered set is accepted
//   sop_type         - 0=SOP, 1=SOP', 2=SOP'', 3=Hard Reset; held until the next acceptance
//   rx_err           - one-cycle pulse with the frame-end strobe of an aborted frame

module phy_rx_4b5b_dec #(
  parameter int MAX_NIB = 528
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bit,
  input  logic       rx_bit_vld,
  input  logic       rx_carrier,
  output logic [3:0] crc_data_in,
  output logic       crc_data_en,
  output logic       crc_data_last,
  output logic       sop_det,
  output logic [1:0] sop_type,
  output logic       rx_err
);

  localparam int NW = $clog2(MAX_NIB + 1);

  // K-codes, written b4..b0
  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  localparam logic [1:0] TYPE_SOP  = 2'd0;
  localparam logic [1:0] TYPE_SOP1 = 2'd1;
  localparam logic [1:0] TYPE_SOP2 = 2'd2;
  localparam logic [1:0] TYPE_HRST = 2'd3;

  // gap_q reads 3 in the third cycle after a strobe; issuing then puts the
  // next strobe 4 clk after the previous one.
  localparam logic [1:0] GAP_SAT = 2'd3;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Number of matching symbol slots; w[4:0] holds the oldest symbol.
  function automatic logic [2:0] os_score(input logic [19:0] w,
                                          input logic [4:0]  s0,
                                          input logic [4:0]  s1,
                                          input logic [4:0]  s2,
                                          input logic [4:0]  s3);
    os_score = {2'b00, (w[4:0]   == s0)} + {2'b00, (w[9:5]   == s1)} +
               {2'b00, (w[14:10] == s2)} + {2'b00, (w[19:15] == s3)};
  endfunction

  // Returns {is_data, nibble}; anything outside the 16 data codes reports is_data=0.
  function automatic logic [4:0] dec_data(input logic [4:0] s);
    case (s)
      5'b11110: dec_data = {1'b1, 4'h0};
      5'b01001: dec_data = {1'b1, 4'h1};
      5'b10100: dec_data = {1'b1, 4'h2};
      5'b10101: dec_data = {1'b1, 4'h3};
      5'b01010: dec_data = {1'b1, 4'h4};
      5'b01011: dec_data = {1'b1, 4'h5};
      5'b01110: dec_data = {1'b1, 4'h6};
      5'b01111: dec_data = {1'b1, 4'h7};
      5'b10010: dec_data = {1'b1, 4'h8};
      5'b10011: dec_data = {1'b1, 4'h9};
      5'b10110: dec_data = {1'b1, 4'hA};
      5'b10111: dec_data = {1'b1, 4'hB};
      5'b11010: dec_data = {1'b1, 4'hC};
      5'b11011: dec_data = {1'b1, 4'hD};
      5'b11100: dec_data = {1'b1, 4'hE};
      5'b11101: dec_data = {1'b1, 4'hF};
      default:  dec_data = 5'b0_0000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [19:0]     win_q, win_d;
  logic [4:0]      sym_q, sym_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [NW-1:0]   nib_cnt_q, nib_cnt_d;
  logic [1:0]      gap_q, gap_d;
  logic            err_q, err_d;
  logic [3:0]      data_q, data_d;
  logic            en_q, en_d;
  logic            last_q, last_d;
  logic            sop_det_q, sop_det_d;
  logic [1:0]      sop_type_q, sop_type_d;
  logic            rx_err_q, rx_err_d;

  logic [19:0]     win_shift;
  logic [4:0]      sym_full;
  logic [4:0]      sym_dec;
  logic            hit_hr, hit_sop, hit_sop1, hit_sop2;
  logic            nib_full;

  // New bits enter at the top so the first-received bit ends up as b0.
  assign win_shift = {rx_bit, win_q[19:1]};
  assign sym_full  = {rx_bit, sym_q[4:1]};
  assign sym_dec   = dec_data(sym_full);
  assign nib_full  = (nib_cnt_q == NW'(MAX_NIB));

  // Ordered sets tolerate one corrupted symbol.
  assign hit_hr   = os_score(win_shift, K_RST1,  K_RST1,  K_RST1,  K_RST2 ) >= 3'd3;
  assign hit_sop  = os_score(win_shift, K_SYNC1, K_SYNC1, K_SYNC1, K_SYNC2) >= 3'd3;
  assign hit_sop1 = os_score(win_shift, K_SYNC1, K_SYNC1, K_SYNC3, K_SYNC3) >= 3'd3;
  assign hit_sop2 = os_score(win_shift, K_SYNC1, K_SYNC3, K_SYNC1, K_SYNC3) >= 3'd3;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    sym_d      = sym_q;
    bit_cnt_d  = bit_cnt_q;
    nib_cnt_d  = nib_cnt_q;
    err_d      = err_q;
    data_d     = data_q;
    en_d       = 1'b0;
    last_d     = 1'b0;
    sop_det_d  = 1'b0;
    sop_type_d = sop_type_q;
    rx_err_d   = 1'b0;

    case (state_q)
      HUNT: begin
        if (!rx_carrier) begin
          win_d = '0;
        end else if (rx_bit_vld) begin
          win_d = win_shift;
          if (hit_hr) begin
            // Hard Reset is reported but carries no frame. The window is
            // flushed so trailing symbols of the same set cannot re-trigger.
            sop_det_d  = 1'b1;
            sop_type_d = TYPE_HRST;
            win_d      = '0;
          end else if (hit_sop || hit_sop1 || hit_sop2) begin
            sop_det_d  = 1'b1;
            sop_type_d = hit_sop ? TYPE_SOP : (hit_sop1 ? TYPE_SOP1 : TYPE_SOP2);
            state_d    = DATA;
            bit_cnt_d  = '0;
            nib_cnt_d  = '0;
            sym_d      = '0;
            err_d      = 1'b0;
            win_d      = '0;
          end
        end
      end

      DATA: begin
        if (!rx_carrier) begin
          state_d = CLOSE;
          err_d   = 1'b1;
        end else if (rx_bit_vld) begin
          sym_d = sym_full;
          if (bit_cnt_q == 3'd4) begin
            bit_cnt_d = '0;
            if (sym_dec[4]) begin
              if (nib_full) begin
                // One data symbol too many: drop it and abort.
                state_d = CLOSE;
                err_d   = 1'b1;
              end else begin
                data_d    = sym_dec[3:0];
                en_d      = 1'b1;
                nib_cnt_d = nib_cnt_q + 1'b1;
              end
            end else if (sym_full == K_EOP) begin
              state_d = CLOSE;
              err_d   = 1'b0;
            end else begin
              state_d = CLOSE;
              err_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      CLOSE: begin
        // Bits arriving here are ignored; wait only for the strobe spacing.
        if (gap_q == GAP_SAT) begin
          en_d     = 1'b1;
          last_d   = 1'b1;
          rx_err_d = err_q;
          err_d    = 1'b0;
          state_d  = HUNT;
          win_d    = '0;
        end
      end

      default: begin
        state_d = HUNT;
        win_d   = '0;
      end
    endcase

    if (en_d) begin
      gap_d = 2'd0;
    end else if (gap_q != GAP_SAT) begin
      gap_d = gap_q + 2'd1;
    end else begin
      gap_d = gap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      win_q      <= '0;
      sym_q      <= '0;
      bit_cnt_q  <= '0;
      nib_cnt_q  <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      en_q       <= 1'b0;
      last_q     <= 1'b0;
      sop_det_q  <= 1'b0;
      sop_type_q <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      sym_q      <= sym_d;
      bit_cnt_q  <= bit_cnt_d;
      nib_cnt_q  <= nib_cnt_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      data_q     <= data_d;
      en_q       <= en_d;
      last_q     <= last_d;
      sop_det_q  <= sop_det_d;
      sop_type_q <= sop_type_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign crc_data_in   = data_q;
  assign crc_data_en   = en_q;
  assign crc_data_last = last_q;
  assign sop_det       = sop_det_q;
  assign sop_type      = sop_type_q;
  assign rx_err        = rx_err_q;

endmodule

// File: tb/tb_phy_rx_4b5b_dec.sv
// Directed bench for phy_rx_4b5b_dec: ordered-set hunting, nibble decode, frame close and aborts.
module tb_phy_rx_4b5b_dec;

  logic       clk, rst_n, rx_bit, rx_bit_vld, rx_carrier;
  logic [3:0] crc_data_in;
  logic       crc_data_en, crc_data_last, sop_det, rx_err;
  logic [1:0] sop_type;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // captured strobes
  logic [3:0] q_nib[$];
  logic       q_last[$];
  logic       q_err[$];
  int         q_cyc[$];
  int         sop_cnt = 0;
  int         sop_cyc = 0;
  logic [1:0] sop_t   = 2'd0;
  int         last_vld_cyc = 0;
  int         prev_en_cyc  = -1;
  int         min_gap      = 1000;
  int         stray        = 0;

  localparam logic [4:0] S1  = 5'b11000;
  localparam logic [4:0] S2  = 5'b10001;
  localparam logic [4:0] S3  = 5'b00110;
  localparam logic [4:0] R1  = 5'b00111;
  localparam logic [4:0] R2  = 5'b11001;
  localparam logic [4:0] EOP = 5'b01101;
  localparam logic [4:0] BAD = 5'b00000;
  localparam int         MAXN = 528;

  logic [4:0] dcode [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                             5'b01010, 5'b01011, 5'b01110, 5'b01111,
                             5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101};

  phy_rx_4b5b_dec #(.MAX_NIB(MAXN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_bit        (rx_bit),
    .rx_bit_vld    (rx_bit_vld),
    .rx_carrier    (rx_carrier),
    .crc_data_in   (crc_data_in),
    .crc_data_en   (crc_data_en),
    .crc_data_last (crc_data_last),
    .sop_det       (sop_det),
    .sop_type      (sop_type),
    .rx_err        (rx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // Capture every strobe and pulse at the falling edge.
  initial forever begin
    @(negedge clk);
    if (crc_data_en === 1'b1) begin
      q_nib.push_back(crc_data_in);
      q_last.push_back(crc_data_last);
      q_err.push_back(rx_err);
      q_cyc.push_back(cyc);
      if (prev_en_cyc >= 0 && (cyc - prev_en_cyc) < min_gap) min_gap = cyc - prev_en_cyc;
      prev_en_cyc = cyc;
    end else if (crc_data_last === 1'b1 || rx_err === 1'b1) begin
      stray++;
    end
    if (sop_det === 1'b1) begin
      sop_cnt++;
      sop_cyc = cyc;
      sop_t   = sop_type;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_bit       = b;
    rx_bit_vld   = 1'b1;
    last_vld_cyc = cyc;
    @(negedge clk);
    rx_bit_vld   = 1'b0;
  endtask

  task automatic send_sym(input logic [4:0] c);
    for (int i = 0; i < 5; i++) send_bit(c[i]);
  endtask

  task automatic send_os(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    send_sym(a); send_sym(b); send_sym(c); send_sym(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    q_nib.delete(); q_last.delete(); q_err.delete(); q_cyc.delete();
    sop_cnt = 0;
  endtask

  // Drop carrier briefly while hunting so the window starts empty.
  task automatic quiet();
    @(negedge clk);
    rx_carrier = 1'b0;
    idle(2);
    rx_carrier = 1'b1;
    idle(1);
    clr();
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++; if (crc_data_in !== 4'h0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", crc_data_in); end
    n_vec++; if (crc_data_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b expected 0", crc_data_en); end
    n_vec++; if (crc_data_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", crc_data_last); end
    n_vec++; if (sop_det !== 1'b0) begin n_err++; $display("FAIL reset_sop_det: got %b expected 0", sop_det); end
    n_vec++; if (sop_type !== 2'd0) begin n_err++; $display("FAIL reset_sop_type: got %0d expected 0", sop_type); end
    n_vec++; if (rx_err !== 1'b0) begin n_err++; $display("FAIL reset_rx_err: got %b expected 0", rx_err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_sop_data();
    int sop_end, d0_end;
    quiet();
    send_os(S1, S1, S1, S2);
    sop_end = last_vld_cyc;
    idle(2);
    n_vec++; if (sop_cnt !== 1) begin n_err++; $display("FAIL sop_count: got %0d expected 1", sop_cnt); end
    n_vec++; if (sop_t !== 2'd0) begin n_err++; $display("FAIL sop_type0: got %0d expected 0", sop_t); end
    n_vec++; if (sop_cyc !== sop_end + 1) begin n_err++; $display("FAIL sop_latency: got cycle %0d expected %0d", sop_cyc, sop_end + 1); end
    send_sym(dcode[4]);
    d0_end = last_vld_cyc;
    send_sym(dcode[2]);
    send_sym(EOP);
    idle(8);
    n_vec++;
    if (q_nib.size() !== 3) begin
      n_err++; $display("FAIL frame_strobes: got %0d expected 3", q_nib.size());
    end else begin
      n_vec++; if (q_nib[0] !== 4'h4 || q_last[0] !== 1'b0) begin n_err++; $display("FAIL nib0: got %0h/last%b expected 4/last0", q_nib[0], q_last[0]); end
      n_vec++; if (q_nib[1] !== 4'h2 || q_last[1] !== 1'b0) begin n_err++; $display("FAIL nib1: got %0h/last%b expected 2/last0", q_nib[1], q_last[1]); end
      n_vec++; if (q_last[2] !== 1'b1 || q_err[2] !== 1'b0) begin n_err++; $display("FAIL frame_end: got last%b err%b expected last1 err0", q_last[2], q_err[2]); end
      n_vec++; if (q_nib[2] !== 4'h2) begin n_err++; $display("FAIL data_hold: got %0h expected 2", q_nib[2]); end
      n_vec++; if (q_cyc[0] !== d0_end + 1) begin n_err++; $display("FAIL nib_latency: got cycle %0d expected %0d", q_cyc[0], d0_end + 1); end
    end
  endtask

  task automatic test_preamble_sop1();
    logic [31:0] pre;
    pre = 32'h5555_5555;
    quiet();
    for (int i = 0; i < 32; i++) send_bit(pre[i]);
    send_os(S1, S1, S3, S3);
    send_sym(EOP);
    idle(8);
    n_vec++; if (sop_cnt !== 1) begin n_err++; $display("FAIL sop1_count: got %0d expected 1", sop_cnt); end
    n_vec++; if (sop_t !== 2'd1) begin n_err++; $display("FAIL sop1_type: got %0d expected 1", sop_t); end
  endtask

  task automatic test_sop2_zero_nibble();
    quiet();
    send_os(S1, S3, S1, S3);
    idle(2);
    n_vec++; if (sop_cnt !== 1 || sop_t !== 2'd2) begin n_err++; $display("FAIL sop2: got count %0d type %0d expected count 1 type 2", sop_cnt, sop_t); end
    send_sym(EOP);
    idle(8);
    n_vec++;
    if (q_nib.size() !== 1) begin
      n_err++; $display("FAIL empty_frame_strobes: got %0d expected 1", q_nib.size());
    end else begin
      n_vec++; if (q_last[0] !== 1'b1 || q_err[0] !== 1'b0) begin n_err++; $display("FAIL empty_frame_end: got last%b err%b expected last1 err0", q_last[0], q_err[0]); end
    end
  endtask

  task automatic test_corrupt();
    quiet();
    send_os(S1, BAD, S1, S2);
    idle(2);
    n_vec++; if (sop_cnt !== 1 || sop_t !== 2'd0) begin n_err++; $display("FAIL one_corrupt: got count %0d type %0d expected count 1 type 0", sop_cnt, sop_t); end
    send_sym(EOP);
    idle(8);
    quiet();
    send_os(S1, BAD, BAD, S2);
    idle(4);
    n_vec++; if (sop_cnt !== 0) begin n_err++; $display("FAIL two_corrupt: got %0d sop_det expected 0", sop_cnt); end
  endtask

  task automatic test_hard_reset();
    quiet();
    send_os(R1, R1, R1, R2);
    idle(2);
    n_vec++; if (sop_cnt !== 1 || sop_t !== 2'd3) begin n_err++; $display("FAIL hard_reset: got count %0d type %0d expected count 1 type 3", sop_cnt, sop_t); end
    send_sym(dcode[5]);
    send_sym(EOP);
    idle(8);
    n_vec++; if (q_nib.size() !== 0) begin n_err++; $display("FAIL hard_reset_no_data: got %0d strobes expected 0", q_nib.size()); end
    n_vec++; if (sop_type !== 2'd3) begin n_err++; $display("FAIL sop_type_hold: got %0d expected 3", sop_type); end
  endtask

  task automatic test_carrier_hunt();
    quiet();
    send_sym(S1);
    send_sym(S1);
    @(negedge clk);
    rx_carrier = 1'b0;
    idle(2);
    rx_carrier = 1'b1;
    send_sym(S1);
    send_sym(S2);
    idle(6);
    n_vec++; if (sop_cnt !== 0 || q_nib.size() !== 0) begin n_err++; $display("FAIL hunt_carrier_clear: got sop %0d strobes %0d expected 0 0", sop_cnt, q_nib.size()); end
  endtask

  task automatic test_abort_invalid();
    quiet();
    send_os(S1, S1, S1, S2);
    send_sym(dcode[10]);
    send_sym(BAD);
    idle(10);
    n_vec++;
    if (q_nib.size() !== 2) begin
      n_err++; $display("FAIL abort_strobes: got %0d expected 2", q_nib.size());
    end else begin
      n_vec++; if (q_nib[0] !== 4'hA || q_last[0] !== 1'b0 || q_err[0] !== 1'b0) begin n_err++; $display("FAIL abort_nib: got %0h/last%b/err%b expected a/last0/err0", q_nib[0], q_last[0], q_err[0]); end
      n_vec++; if (q_last[1] !== 1'b1 || q_err[1] !== 1'b1) begin n_err++; $display("FAIL abort_end: got last%b err%b expected last1 err1", q_last[1], q_err[1]); end
      n_vec++; if (q_cyc[1] - q_cyc[0] < 4) begin n_err++; $display("FAIL abort_gap: got %0d expected >=4", q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_carrier_abort();
    quiet();
    send_os(S1, S1, S1, S2);
    send_sym(dcode[1]);
    @(negedge clk);
    rx_carrier = 1'b0;
    idle(8);
    rx_carrier = 1'b1;
    idle(2);
    n_vec++;
    if (q_nib.size() !== 2) begin
      n_err++; $display("FAIL carrier_strobes: got %0d expected 2", q_nib.size());
    end else begin
      n_vec++; if (q_nib[0] !== 4'h1) begin n_err++; $display("FAIL carrier_nib: got %0h expected 1", q_nib[0]); end
      n_vec++; if (q_last[1] !== 1'b1 || q_err[1] !== 1'b1) begin n_err++; $display("FAIL carrier_end: got last%b err%b expected last1 err1", q_last[1], q_err[1]); end
      n_vec++; if (q_cyc[1] - q_cyc[0] !== 4) begin n_err++; $display("FAIL carrier_gap: got %0d expected 4", q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_max_frame(input int ndata, input logic with_eop, input logic exp_err);
    int bad;
    quiet();
    send_os(S1, S1, S1, S2);
    for (int i = 0; i < ndata; i++) send_sym(dcode[i % 16]);
    if (with_eop) send_sym(EOP);
    idle(10);
    n_vec++;
    if (q_nib.size() !== MAXN + 1) begin
      n_err++; $display("FAIL max_strobes(%0d): got %0d expected %0d", ndata, q_nib.size(), MAXN + 1);
    end else begin
      bad = 0;
      for (int i = 0; i < MAXN; i++)
        if (q_nib[i] !== 4'(i % 16) || q_last[i] !== 1'b0 || q_err[i] !== 1'b0) bad++;
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL max_nibbles(%0d): got %0d bad entries expected 0", ndata, bad); end
      n_vec++; if (q_last[MAXN] !== 1'b1 || q_err[MAXN] !== exp_err) begin n_err++; $display("FAIL max_end(%0d): got last%b err%b expected last1 err%b", ndata, q_last[MAXN], q_err[MAXN], exp_err); end
    end
  endtask

  task automatic test_reset_midframe();
    quiet();
    send_os(S1, S1, S3, S3);
    send_sym(dcode[7]);
    send_bit(1'b1);
    send_bit(1'b0);
    n_vec++; if (crc_data_in !== 4'h7 || sop_type !== 2'd1) begin n_err++; $display("FAIL pre_reset: got data %0h type %0d expected 7 1", crc_data_in, sop_type); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (crc_data_in !== 4'h0 || sop_type !== 2'd0) begin n_err++; $display("FAIL async_reset: got data %0h type %0d expected 0 0", crc_data_in, sop_type); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    n_vec++; if (q_nib.size() !== 1) begin n_err++; $display("FAIL reset_discard: got %0d strobes expected 1", q_nib.size()); end
    send_os(S1, S1, S1, S2);
    send_sym(EOP);
    idle(8);
    n_vec++; if (q_nib.size() !== 2 || q_last[q_nib.size() - 1] !== 1'b1) begin n_err++; $display("FAIL post_reset_frame: got %0d strobes expected 2 ending in last", q_nib.size()); end
  endtask

  task automatic test_global();
    n_vec++; if (min_gap < 4) begin n_err++; $display("FAIL strobe_spacing: got %0d expected >=4", min_gap); end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL stray_last_err: got %0d expected 0", stray); end
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_bit     = 1'b0;
    rx_bit_vld = 1'b0;
    rx_carrier = 1'b1;
    test_reset();
    test_sop_data();
    test_preamble_sop1();
    test_sop2_zero_nibble();
    test_corrupt();
    test_hard_reset();
    test_carrier_hunt();
    test_abort_invalid();
    test_carrier_abort();
    test_max_frame(MAXN, 1'b1, 1'b0);
    test_max_frame(MAXN + 1, 1'b0, 1'b1);
    test_reset_midframe();
    test_global();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_rx_4b5b_dec.md
PHY_RX_4B5B_DEC -- requirements
Module: phy_rx_4b5b_dec

Interface
REQ-001 Parameter MAX_NIB, default 528, maximum data nibbles per frame (SOP through CRC) before overflow abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_bit  input  1  decoded line bit from the BMC receiver; valid only when rx_bit_vld=1.
REQ-005 rx_bit_vld  input  1  one-cycle strobe per received bit; consecutive strobes are at least 2 clk apart.
REQ-006 rx_carrier  input  1  BMC receiver has carrier; 1->0 mid-frame is an abort.
REQ-007 crc_data_in  output  4  decoded nibble to the downstream CRC32 stage; held stable until the next nibble.
REQ-008 crc_data_en  output  1  one-cycle nibble strobe; also asserted together with crc_data_last to close a frame.
REQ-009 crc_data_last  output  1  frame-end marker; only ever high while crc_data_en=1.
REQ-010 sop_det  output  1  one-cycle pulse on ordered-set acceptance.
REQ-011 sop_type  output  2  0=SOP, 1=SOP', 2=SOP'', 3=Hard Reset; updated with sop_det and held.
REQ-012 rx_err  output  1  one-cycle pulse, coincident with the abort frame-end strobe.

Function
REQ-013 Symbol bit order: first received bit is b0; codes below are written b4..b0.
REQ-014 Data codes 0..F: 11110,01001,10100,10101,01010,01011,01110,01111,10010,10011,10110,10111,11010,11011,11100,11101; K-codes: Sync-1 11000, Sync-2 10001, Sync-3 00110, RST-1 00111, RST-2 11001, EOP 01101.
REQ-015 State machine: HUNT, DATA, CLOSE; reset state HUNT.
REQ-016 HUNT: 20-bit shift window updated on every rx_bit_vld; after each shift, the window is compared as four symbols against SOP (S1,S1,S1,S2), SOP' (S1,S1,S3,S3), SOP'' (S1,S3,S1,S3) and Hard Reset (R1,R1,R1,R2).
REQ-017 An ordered set is accepted when at least 3 of its 4 symbols match; when several sets match, priority is Hard Reset, SOP, SOP', SOP''.
REQ-018 Acceptance: sop_det pulses the cycle after the qualifying rx_bit_vld; SOP/SOP'/SOP'' enter DATA with the bit counter and nibble counter cleared; Hard Reset stays in HUNT.
REQ-019 DATA: 5 bits are collected per symbol; the cycle after the 5th rx_bit_vld: a data code drives crc_data_in and pulses crc_data_en with crc_data_last=0; EOP enters CLOSE normally; any other code enters CLOSE with an error.
REQ-020 Abort causes (enter CLOSE with error): invalid or K-code symbol other than EOP, rx_carrier=0, nibble counter reaching MAX_NIB with another data symbol arriving.
REQ-021 CLOSE: issues crc_data_en=1 with crc_data_last=1 for one cycle, no earlier than 4 clk after the previous crc_data_en (gap counter); rx_err pulses in the same cycle on an abort; then returns to HUNT.
REQ-022 Between crc_data_en pulses, crc_data_in does not change; successive pulses are never closer than 4 clk.
REQ-023 A frame with zero data nibbles that receives EOP still issues the frame-end strobe.
REQ-024 rx_bit_vld during CLOSE is ignored; the HUNT window is cleared to all-zero on entry to HUNT.
REQ-025 rx_carrier=0 in HUNT only clears the window; no strobe is issued.

Reset
REQ-026 On rst_n=0: state HUNT; window, counters cleared; crc_data_in=0, crc_data_en=0, crc_data_last=0, sop_det=0, sop_type=0, rx_err=0.
REQ-027 Reset mid-frame discards the frame with no frame-end strobe; the downstream CRC32 stage shares rst_n.

Verification
REQ-028 S1,S1,S1,S2, then data 0x4,0x2, EOP -> sop_det, sop_type=0; nibble strobes 4 then 2; final strobe with last=1; rx_err=0.
REQ-029 S1,S1,S3,S3 preceded by random preamble bits -> sop_det with sop_type=1 exactly once; S1,S3,S1,S3 -> sop_type=2.
REQ-030 S1, 00000, S1, S2 (one corrupted symbol) -> accepted as SOP; two corrupted -> no sop_det.
REQ-031 R1,R1,R1,R2 -> sop_det, sop_type=3, state stays HUNT, no crc_data_en.
REQ-032 SOP, data 0xA, symbol 00000 -> nibble A strobe, then last strobe 4+ clk later with rx_err=1.
REQ-033 SOP, data 0x1, rx_carrier drops 1 clk after the nibble strobe -> last strobe exactly 4 clk after the nibble strobe, rx_err=1; SOP + MAX_NIB+1 data symbols -> abort after nibble MAX_NIB.
